wshb_mire_slave: RTL and testbench

// Wishbone B4 responder (slave) that serves a procedurally generated HDISP x VDISP

---
 rtl/wshb_mire_slave.sv | 183 ++++++++++++++++++
 tb/tb_wshb_mire_slave.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_mire_slave.sv
// Wishbone B4 slave that serves a generated test-pattern frame, one word per pixel,
// plus CTRL/COLOR registers that select the pattern.
module wshb_mire_slave #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          GRID     = 16,
  parameter logic [31:0] CTRL_ADR = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_ms,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic        ack,
  output logic        err,
  output logic [31:0] dat_sm
);

  localparam int FRAME = HDISP * VDISP;
  localparam int BAR_W = HDISP / 8;
  localparam int XW    = ($clog2(HDISP) > 8) ? $clog2(HDISP) : 8;
  localparam int YW    = ($clog2(VDISP) > 8) ? $clog2(VDISP) : 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [29:0] CTRL_IDX = CTRL_ADR[31:2];

  typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_STREAM, S_ERROR} state_t;
  state_t state, state_nxt;

  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic [BW-1:0] bar_cnt, cbar_cnt;
  logic [2:0]    bar, cbar;
  logic [29:0]   nxt_idx;
  logic [1:0]    ctrl;
  logic [23:0]   color;
  logic [29:0]   idx;
  logic          is_frame, is_ctrl, is_color, valid, serve, frame_rd;
  logic [23:0]   pix;
  logic [31:0]   rdata;
  logic          unused;

  assign idx      = adr[31:2];
  assign is_frame = idx < 30'(FRAME);
  assign is_ctrl  = (idx == CTRL_IDX);
  assign is_color = (idx == CTRL_IDX + 30'd1);
  // Frame reads must follow the fetch sequence; idx 0 always restarts it.
  assign valid    = is_ctrl | is_color |
                    (is_frame & (we | (idx == 30'd0) | (idx == nxt_idx)));
  assign serve    = cyc & stb & ((state == S_IDLE) | (state == S_STREAM));
  assign frame_rd = serve & is_frame & ~we & valid;
  assign ack      = (state == S_SINGLE) | (state == S_STREAM);
  assign err      = (state == S_ERROR);
  assign unused   = ^{bte, adr[1:0], dat_ms[31:24], sel[3]};

  // Handshake state: stream keeps accepting beats while the master signals 010.
  always_comb begin
    state_nxt = S_IDLE;
    if (serve) begin
      if (!valid) begin
        state_nxt = S_ERROR;
      end else if (cti == 3'b010) begin
        state_nxt = S_STREAM;
      end else begin
        state_nxt = S_SINGLE;
      end
    end else begin
      state_nxt = S_IDLE;
    end
  end

  // Raster position of the pixel being served, reloaded to the origin on idx 0.
  always_comb begin
    if (idx == 30'd0) begin
      cx       = '0;
      cy       = '0;
      cbar     = '0;
      cbar_cnt = '0;
    end else begin
      cx       = x;
      cy       = y;
      cbar     = bar;
      cbar_cnt = bar_cnt;
    end
  end

  // Pattern generator.
  always_comb begin
    pix = 24'h000000;
    case (ctrl)
      2'd0: begin
        if (((int'(cx) % GRID) == 0) || ((int'(cy) % GRID) == 0)) begin
          pix = 24'hFF_FFFF;
        end else begin
          pix = 24'h00_0000;
        end
      end
      2'd1:    pix = {{8{cbar[2]}}, {8{cbar[1]}}, {8{cbar[0]}}};
      2'd2:    pix = color;
      2'd3:    pix = {cx[7:0], cy[7:0], 8'h00};
      default: pix = 24'h000000;
    endcase
  end

  // Read data mux.
  always_comb begin
    if (is_ctrl) begin
      rdata = {30'd0, ctrl};
    end else if (is_color) begin
      rdata = {8'h00, color};
    end else begin
      rdata = {8'h00, pix};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registers, read data and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_sm  <= 32'd0;
      ctrl    <= 2'd0;
      color   <= 24'd0;
      x       <= '0;
      y       <= '0;
      bar     <= '0;
      bar_cnt <= '0;
      nxt_idx <= 30'd0;
    end else begin
      if (serve && valid && !we) begin
        dat_sm <= rdata;
      end else begin
        dat_sm <= 32'd0;
      end
      if (serve && we && is_ctrl && sel[0]) begin
        ctrl <= dat_ms[1:0];
      end
      if (serve && we && is_color) begin
        if (sel[0]) color[7:0]   <= dat_ms[7:0];
        if (sel[1]) color[15:8]  <= dat_ms[15:8];
        if (sel[2]) color[23:16] <= dat_ms[23:16];
      end
      if (frame_rd) begin
        if (cx == XW'(HDISP - 1)) begin
          x       <= '0;
          bar     <= '0;
          bar_cnt <= '0;
          if (cy == YW'(VDISP - 1)) begin
            y       <= '0;
            nxt_idx <= 30'd0;
          end else begin
            y       <= cy + YW'(1);
            nxt_idx <= idx + 30'd1;
          end
        end else begin
          x       <= cx + XW'(1);
          y       <= cy;
          nxt_idx <= idx + 30'd1;
          // Bar index = x / (HDISP/8), tracked incrementally.
          if (cbar_cnt == BW'(BAR_W - 1)) begin
            bar_cnt <= '0;
            bar     <= cbar + 3'd1;
          end else begin
            bar_cnt <= cbar_cnt + BW'(1);
            bar     <= cbar;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wshb_mire_slave.sv
// Self-checking bench for wshb_mire_slave: vector table, hand-written corner
// sequences and randomized traffic checked against an index-based frame model.
module tb_wshb_mire_slave;

  localparam int H     = 80;
  localparam int V     = 24;
  localparam int GRID  = 16;
  localparam int FRAME = H * V;
  localparam logic [31:0] CTRL_ADR  = 32'h0020_0000;
  localparam logic [31:0] COLOR_ADR = 32'h0020_0004;
  localparam logic [29:0] CTRL_IDX  = 30'h0008_0000;
  localparam logic [29:0] COLOR_IDX = 30'h0008_0001;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ack, err;
  logic [31:0] adr, dat_ms, dat_sm;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int checks = 0;
  int errors = 0;

  int          m_nxt;
  logic [1:0]  m_ctrl;
  logic [23:0] m_color;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        e;
    logic [31:0] q;
  } vec_t;
  vec_t tbl[$];

  wshb_mire_slave #(.HDISP(H), .VDISP(V), .GRID(GRID), .CTRL_ADR(CTRL_ADR)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
    .dat_ms(dat_ms), .cti(cti), .bte(bte), .ack(ack), .err(err), .dat_sm(dat_sm)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Pixel value straight from the pattern rules, position derived from the word index.
  function automatic logic [31:0] model_pix(input int i);
    int x, y, b;
    logic [31:0] xv, yv, bv;
    x = i % H;
    y = i / H;
    b = x / (H / 8);
    xv = x; yv = y; bv = b;
    case (m_ctrl)
      2'd0:    return (((x % GRID) == 0) || ((y % GRID) == 0)) ? 32'h00FF_FFFF : 32'h0;
      2'd1:    return {8'h00, {8{bv[2]}}, {8{bv[1]}}, {8{bv[0]}}};
      2'd2:    return {8'h00, m_color};
      default: return {8'h00, xv[7:0], yv[7:0], 8'h00};
    endcase
  endfunction

  task automatic model_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, output logic e, output logic [31:0] q);
    int i;
    i = int'(a[31:2]);
    e = 1'b0;
    q = 32'h0;
    if (a[31:2] == CTRL_IDX) begin
      if (w) begin
        if (s[0]) m_ctrl = d[1:0];
      end else q = {30'h0, m_ctrl};
    end else if (a[31:2] == COLOR_IDX) begin
      if (w) begin
        for (int k = 0; k < 3; k++) if (s[k]) m_color[8*k +: 8] = d[8*k +: 8];
      end else q = {8'h00, m_color};
    end else if (i < FRAME) begin
      if (!w) begin
        if (i == 0 || i == m_nxt) begin
          q = model_pix(i);
          m_nxt = (i == FRAME - 1) ? 0 : i + 1;
        end else e = 1'b1;
      end
    end else e = 1'b1;
  endtask

  task automatic add(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input logic e, input logic [31:0] q);
    vec_t v;
    v.w = w; v.a = a; v.s = s; v.d = d; v.e = e; v.q = q;
    tbl.push_back(v);
  endtask

  task automatic classic(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic use_tbl, input logic te,
                         input logic [31:0] tq, input string nm);
    logic me, xe;
    logic [31:0] mq, xq;
    int n;
    model_access(w, a, s, d, me, mq);
    xe = use_tbl ? te : me;
    xq = use_tbl ? tq : mq;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_ms = d; cti = 3'b000;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && !err && n < 4);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, xe});
    chk({nm, "_ack"}, {31'd0, ack}, {31'd0, ~xe});
    chk({nm, "_lat"}, n, 1);
    if (!w && !xe) chk({nm, "_dat"}, dat_sm, xq);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_pulse"}, {30'd0, ack, err}, 32'd0);
  endtask

  task automatic burst(input int start, input int n, input int bad_at, input string nm);
    int beat, cyc_n, i;
    logic me, saw_err;
    logic [31:0] mq;
    beat = 0; cyc_n = 0; i = start; saw_err = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'(i) << 2;
    cti = (n == 1) ? 3'b111 : 3'b010;
    while (beat < n && !saw_err && cyc_n < n + 8) begin
      @(posedge clk); #1;
      cyc_n++;
      if (ack || err) begin
        model_access(1'b0, adr, 4'hF, 32'd0, me, mq);
        chk({nm, "_err"}, {31'd0, err}, {31'd0, me});
        if (!me) chk({nm, "_dat"}, dat_sm, mq);
        chk({nm, "_excl"}, {31'd0, ack & err}, 32'd0);
        beat++;
        saw_err = me;
        i = i + 1 + ((beat == bad_at) ? 3 : 0);
        adr = 32'(i) << 2;
        cti = (beat == n - 1) ? 3'b111 : 3'b010;
      end
    end
    if (!saw_err) begin
      chk({nm, "_beats"}, beat, n);
      chk({nm, "_cycles"}, cyc_n, n);
    end
    @(posedge clk); #1;
    chk({nm, "_tail"}, {30'd0, ack, err}, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
  endtask

  // Streams k beats and returns with the bus still held, ack high.
  task automatic stream_beats(input int start, input int k);
    int got, n, i;
    logic me;
    logic [31:0] mq;
    got = 0; n = 0; i = start;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; cti = 3'b010; adr = 32'(i) << 2;
    while (got < k && n < k + 4) begin
      @(posedge clk); #1;
      n++;
      if (ack || err) begin
        model_access(1'b0, adr, 4'hF, 32'd0, me, mq);
        chk("strm_err", {31'd0, err}, {31'd0, me});
        if (!me) chk("strm_dat", dat_sm, mq);
        got++; i++;
        adr = 32'(i) << 2;
      end
    end
    chk("strm_beats", got, k);
  endtask

  initial begin
    int k, last, cyc_n, op, ri;
    logic me;
    logic [31:0] mq;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; sel = 4'h0;
    dat_ms = 32'd0; cti = 3'b000; bte = 2'b00;
    m_nxt = 0; m_ctrl = 2'd0; m_color = 24'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", dat_sm, 32'd0);
    rst = 1'b0;

    add(1'b0, CTRL_ADR,      4'hF,   32'd0,          1'b0, 32'h0000_0000);
    add(1'b0, COLOR_ADR,     4'hF,   32'd0,          1'b0, 32'h0000_0000);
    add(1'b0, 32'h0000_0000, 4'hF,   32'd0,          1'b0, 32'h00FF_FFFF);
    add(1'b0, 32'h0000_0004, 4'hF,   32'd0,          1'b0, 32'h00FF_FFFF);
    add(1'b0, 32'h0000_0008, 4'hF,   32'd0,          1'b0, 32'h00FF_FFFF);
    add(1'b0, 32'h0000_0014, 4'hF,   32'd0,          1'b1, 32'h0000_0000);
    add(1'b0, 32'h0000_000C, 4'hF,   32'd0,          1'b0, 32'h00FF_FFFF);
    add(1'b0, 32'h0000_1E00, 4'hF,   32'd0,          1'b1, 32'h0000_0000);
    add(1'b1, 32'h0000_0190, 4'hF,   32'hDEAD_BEEF,  1'b0, 32'h0000_0000);
    add(1'b0, 32'h0000_0010, 4'hF,   32'd0,          1'b0, 32'h00FF_FFFF);
    add(1'b1, CTRL_ADR,      4'hF,   32'h0000_0002,  1'b0, 32'h0000_0000);
    add(1'b1, COLOR_ADR,     4'b0111, 32'h0012_AB34, 1'b0, 32'h0000_0000);
    add(1'b0, CTRL_ADR,      4'hF,   32'd0,          1'b0, 32'h0000_0002);
    add(1'b0, COLOR_ADR,     4'hF,   32'd0,          1'b0, 32'h0012_AB34);
    add(1'b0, 32'h0000_0014, 4'hF,   32'd0,          1'b0, 32'h0012_AB34);
    add(1'b1, COLOR_ADR,     4'b0001, 32'h0000_00FF, 1'b0, 32'h0000_0000);
    add(1'b0, COLOR_ADR,     4'hF,   32'd0,          1'b0, 32'h0012_ABFF);
    add(1'b0, 32'h0000_0018, 4'hF,   32'd0,          1'b0, 32'h0012_ABFF);
    add(1'b1, CTRL_ADR,      4'hF,   32'h0000_0003,  1'b0, 32'h0000_0000);
    add(1'b0, 32'h0000_001C, 4'hF,   32'd0,          1'b0, 32'h0007_0000);
    add(1'b1, CTRL_ADR,      4'hF,   32'h0000_0001,  1'b0, 32'h0000_0000);
    add(1'b0, 32'h0000_0020, 4'hF,   32'd0,          1'b0, 32'h0000_0000);
    add(1'b0, 32'h0000_0000, 4'hF,   32'd0,          1'b0, 32'h0000_0000);
    add(1'b1, 32'h0030_0000, 4'hF,   32'd0,          1'b1, 32'h0000_0000);
    add(1'b0, 32'h0030_0000, 4'hF,   32'd0,          1'b1, 32'h0000_0000);
    add(1'b1, CTRL_ADR,      4'h0,   32'h0000_0003,  1'b0, 32'h0000_0000);
    add(1'b0, CTRL_ADR,      4'hF,   32'd0,          1'b0, 32'h0000_0001);
    add(1'b1, CTRL_ADR,      4'h1,   32'hFFFF_FFFC,  1'b0, 32'h0000_0000);
    add(1'b0, CTRL_ADR,      4'hF,   32'd0,          1'b0, 32'h0000_0000);

    for (int t = 0; t < tbl.size(); t++) begin
      classic(tbl[t].w, tbl[t].a, tbl[t].s, tbl[t].d, 1'b1, tbl[t].e, tbl[t].q,
              $sformatf("vec%0d", t));
    end

    // Back-to-back classic reads: one ack every second cycle.
    classic(1'b1, CTRL_ADR, 4'h1, 32'd3, 1'b0, 1'b0, 32'd0, "ctrl_ramp");
    cyc = 1'b1; stb = 1'b1; we = 1'b0; cti = 3'b000; adr = 32'd0;
    k = 0; last = -1; cyc_n = 0;
    while (k < 18 && cyc_n < 60) begin
      @(posedge clk); #1;
      cyc_n++;
      if (ack) begin
        model_access(1'b0, adr, 4'hF, 32'd0, me, mq);
        chk("b2b_dat", dat_sm, mq);
        if (last >= 0) chk("b2b_gap", cyc_n - last, 2);
        last = cyc_n;
        k++;
        adr = 32'(k) << 2;
      end
    end
    chk("b2b_count", k, 18);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Whole frame as one burst, then restart at idx 0.
    classic(1'b1, CTRL_ADR, 4'h1, 32'd1, 1'b0, 1'b0, 32'd0, "ctrl_bars");
    burst(0, FRAME, -1, "frame");
    classic(1'b0, 32'd0, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, "restart");
    classic(1'b1, CTRL_ADR, 4'h1, 32'd0, 1'b0, 1'b0, 32'd0, "ctrl_grid");
    burst(0, 2 * H + 3, -1, "grid_rows");
    burst(0, 6, 2, "cross_bad");

    // Abort mid-stream: no transfer on the cyc=0 edge.
    classic(1'b1, CTRL_ADR, 4'h1, 32'd3, 1'b0, 1'b0, 32'd0, "ctrl_ab");
    stream_beats(0, 3);
    cyc = 1'b0;
    @(posedge clk); #1;
    chk("abort_ack", {30'd0, ack, err}, 32'd0);
    @(posedge clk); #1;
    chk("abort_nocyc", {30'd0, ack, err}, 32'd0);
    stb = 1'b0; cti = 3'b000;
    classic(1'b0, 32'h0000_000C, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, "after_abort");

    // Reset in the middle of a burst.
    stream_beats(0, 4);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_ack", {31'd0, ack}, 32'd0);
    chk("rstmid_dat", dat_sm, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    m_nxt = 0; m_ctrl = 2'd0; m_color = 24'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    classic(1'b0, 32'd0, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, "post_rst_px");
    classic(1'b0, CTRL_ADR, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, "post_rst_ctrl");
    classic(1'b0, COLOR_ADR, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, "post_rst_color");

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: classic(1'b1, CTRL_ADR, 4'($urandom_range(0, 15)), $urandom, 1'b0, 1'b0, 32'd0, "r_ctrl");
        1: classic(1'b1, COLOR_ADR, 4'($urandom_range(0, 15)), $urandom, 1'b0, 1'b0, 32'd0, "r_color");
        2: burst(m_nxt, $urandom_range(1, 40), -1, "r_bnxt");
        3: burst(0, $urandom_range(1, 40), -1, "r_b0");
        4: begin
          ri = $urandom_range(0, 2);
          if (ri == 0) ri = m_nxt;
          else if (ri == 1) ri = 0;
          else ri = $urandom_range(0, FRAME + 8);
          classic(1'b0, 32'(ri) << 2, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, "r_rd");
        end
        default: classic(1'b0, ($urandom_range(0, 1) == 1) ? CTRL_ADR : COLOR_ADR, 4'hF, 32'd0,
                         1'b0, 1'b0, 32'd0, "r_reg");
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
